// File: rtl/alu_issue_capture.sv
// Issue/capture sequencer around a gate-level ALU: registers one request, waits a settle window, captures the response.
// Optional result self-check against a behavioural model is enabled with `define ALU_ISSUE_CHECK_EN.
module alu_issue_capture #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [2:0]       rsp_cmd,
    output logic             busy,
    output logic             check_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   alu_a_reg;
    logic [WIDTH-1:0]   alu_b_reg;
    logic [2:0]         alu_cmd_reg;
    logic               rsp_valid_reg;
    logic [WIDTH-1:0]   rsp_result_reg;
    logic               rsp_carry_reg;
    logic               rsp_zero_reg;
    logic               rsp_ovf_reg;
    logic [2:0]         rsp_cmd_reg;

    assign req_ready    = (state_reg == S_IDLE);
    assign busy         = (state_reg == S_SETTLE) || (state_reg == S_HOLD);
    assign alu_operandA = alu_a_reg;
    assign alu_operandB = alu_b_reg;
    assign alu_command  = alu_cmd_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_result   = rsp_result_reg;
    assign rsp_carryout = rsp_carry_reg;
    assign rsp_zero     = rsp_zero_reg;
    assign rsp_overflow = rsp_ovf_reg;
    assign rsp_cmd      = rsp_cmd_reg;

    wire capture_now = (state_reg == S_SETTLE) && (cnt_reg == '0);

    // ALU operand registers only move on an accept edge, keeping the ALU inputs glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_cmd_reg    <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_carry_reg  <= 1'b0;
            rsp_zero_reg   <= 1'b0;
            rsp_ovf_reg    <= 1'b0;
            rsp_cmd_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        alu_a_reg   <= req_a;
                        alu_b_reg   <= req_b;
                        alu_cmd_reg <= req_cmd;
                        cnt_reg     <= CNT_W'(SETTLE_CYCLES - 1);
                        state_reg   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (capture_now) begin
                        rsp_result_reg <= alu_result;
                        rsp_carry_reg  <= alu_carryout;
                        rsp_zero_reg   <= alu_zero;
                        rsp_ovf_reg    <= alu_overflow;
                        rsp_cmd_reg    <= alu_cmd_reg;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= S_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rsp_valid_reg && rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_CHECK_EN
    localparam logic [2:0] c_ADD  = 3'd0;
    localparam logic [2:0] c_SUB  = 3'd1;
    localparam logic [2:0] c_XOR  = 3'd2;
    localparam logic [2:0] c_SLT  = 3'd3;
    localparam logic [2:0] c_AND  = 3'd4;
    localparam logic [2:0] c_NAND = 3'd5;
    localparam logic [2:0] c_NOR  = 3'd6;
    localparam logic [2:0] c_OR   = 3'd7;

    logic        check_err_reg;
    logic [15:0] mismatch_count;

    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic [2:0]       cmd);
        logic [WIDTH-1:0] r;
        r = '0;
        case (cmd)
            c_ADD:   r = a + b;
            c_SUB:   r = a - b;
            c_XOR:   r = a ^ b;
            c_SLT:   r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_AND:   r = a & b;
            c_NAND:  r = ~(a & b);
            c_NOR:   r = ~(a | b);
            c_OR:    r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Only the result is compared; flag behaviour of the gate-level ALU is not modelled.
    always_ff @(posedge clk) begin
        if (reset) begin
            check_err_reg  <= 1'b0;
            mismatch_count <= '0;
        end else if (capture_now &&
                     (alu_result != ref_result(alu_a_reg, alu_b_reg, alu_cmd_reg))) begin
            check_err_reg <= 1'b1;
            if (mismatch_count != 16'hFFFF)
                mismatch_count <= mismatch_count + 16'd1;
        end
    end

    assign check_err = check_err_reg;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: doc/alu_issue_capture.md
Name: alu_issue_capture

Overview:
- Sequencing stage wrapped around the 32-bit ALU: accepts one operation request (operands and 3-bit command) over a valid/ready handshake and registers it onto the ALU inputs.
- Holds the ALU inputs stable for a parameterised settle window, because the ALU is gate-level with real propagation delay.
- Captures result and flags into output registers and presents them downstream over a second valid/ready handshake.
- Sits between the instruction/control logic (upstream) and the ALU, and between the ALU and the writeback path (downstream).

Parameters:
- WIDTH, 32, operand/result width; must match the ALU n parameter.
- SETTLE_CYCLES, 8, clock cycles the ALU inputs are held before capture; legal range 1..255.
- CNT_W, 8, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  upstream request present.
- req_ready  output  1  block can accept a request this cycle.
- req_a  input  WIDTH  operand A (signed).
- req_b  input  WIDTH  operand B (signed).
- req_cmd  input  3  ALU command, using the `c_*` encodings from cmd.v.
- alu_operandA  output  WIDTH  registered operand A to the ALU.
- alu_operandB  output  WIDTH  registered operand B to the ALU.
- alu_command  output  3  registered command to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carry out.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU overflow flag.
- rsp_valid  output  1  captured response available.
- rsp_ready  input  1  downstream accepts the response.
- rsp_result  output  WIDTH  captured result.
- rsp_carryout  output  1  captured carry.
- rsp_zero  output  1  captured zero flag.
- rsp_overflow  output  1  captured overflow flag.
- rsp_cmd  output  3  command that produced this response.
- busy  output  1  high in SETTLE or HOLD.
- check_err  output  1  sticky self-check error (see Optional Feature).

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: state=IDLE, all alu_* and rsp_* outputs 0, rsp_valid 0, busy 0, counter 0, check_err 0. req_ready is 1 in the first cycle after reset deasserts.
- States: IDLE, SETTLE, HOLD (encode in 2 bits; the fourth code recovers to IDLE).
- IDLE: req_ready=1. On req_valid && req_ready at edge N: register req_a, req_b, req_cmd onto alu_*; load counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: req_ready=0. Each edge: if counter==0, capture alu_result/flags into rsp_*, copy alu_command into rsp_cmd, set rsp_valid=1, go to HOLD; else decrement counter.
  - Capture occurs at edge N+SETTLE_CYCLES, so rsp_valid is visible after that edge.
- HOLD: req_ready=0. rsp_* and alu_* are held stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready at an edge: clear rsp_valid, go to IDLE.
  - rsp_* data keeps its last value after the handshake; only rsp_valid drops.
- Throughput: with rsp_ready tied 1, consecutive accepts are SETTLE_CYCLES+2 cycles apart.
- alu_* outputs never change outside an accept edge or reset, so the ALU inputs are glitch-free for the whole window.
- req_valid in SETTLE or HOLD is ignored and is not queued; upstream must hold it until req_ready.
- Reset mid-operation (SETTLE or HOLD): next state IDLE, the in-flight op is discarded, no rsp_valid pulse, alu_* return to 0.
- Reset has priority over any simultaneous handshake.
- No arithmetic is performed in this block apart from the counter decrement; it saturates at 0 and never wraps.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- When defined: a behavioural reference model computes the expected result from the registered operands and command at the capture edge. Expected results per command:
  - ADD: A+B.
  - SUB: A-B.
  - SLT: 1 if signed A<B, else 0.
  - XOR, AND, NAND, NOR, OR: bitwise.
  - Only the result is compared; flags are not checked.
- On mismatch: check_err is set (sticky until reset), and the 16-bit internal register mismatch_count increments, saturating at 0xFFFF.
- When undefined: the model and counter are absent and check_err is tied 0.

Test Plan:
1. Hold reset 3 cycles, release. All rsp_*/alu_* are 0, busy=0, req_ready=1 on the first post-reset cycle.
2. SETTLE_CYCLES=4, ADD with A=0xB0000000, B=0xA0000000 accepted at edge N:
   - alu_operandA=0xB0000000 after edge N.
   - rsp_valid rises at edge N+4 with rsp_result=0x50000000, carry=1, zero=0, overflow=1, rsp_cmd=`c_ADD.
3. Hold rsp_ready=0 for 10 cycles in HOLD while req_valid=1 with new operands:
   - rsp_* unchanged, req_ready=0, alu_* unchanged.
   - Raise rsp_ready: IDLE next edge, new request accepted on the following edge.
4. Back-to-back with rsp_ready=1: SUB 0xF0000000-0xF0000000 gives result 0, carry=1, zero=1, overflow=0; then SLT with A=-6, B=-3 gives result 1. Accepts are exactly 6 cycles apart.
5. Assert reset 2 cycles into SETTLE: state IDLE next edge, rsp_valid never pulses, alu_* are 0.
6. With ALU_ISSUE_CHECK_EN, bench stub forces alu_result=0x1 for XOR A=B=0xFFFFFFFF: check_err=1 from the capture edge, mismatch_count=1; a subsequent correct op leaves check_err=1.
